mem_wait_responder: RTL

Unified instruction/data memory responder for the multicycle RISC-V core. It sits on the memory side of the controller's fetch/load/store port. It accepts one word request at a time, inserts a programmable number of wait cycles, and returns read data or a write acknowledgement with a one-cycle response pulse. The core's controller is the initiator; this block is the responder it stalls on.

---
 rtl/mem_wait_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_wait_responder.sv
// Single-port word memory responder: accepts one request in IDLE, waits LATENCY cycles,
// commits the access and pulses resp_valid for one cycle; requests outside IDLE are ignored.
module mem_wait_responder #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_err;
  logic            commit;
  logic            c_we, c_err;
  logic [AW-1:0]   c_idx;
  logic [31:0]     c_wdata;

  // Full upper-address compare so out-of-range addresses never alias onto real words.
  assign req_err = (req_addr[1:0] != 2'b00) |
                   ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    commit  = 1'b0;
    c_we    = we_q;
    c_err   = err_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          err_d   = req_err;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            // Zero-wait: the accept edge doubles as the commit edge.
            commit  = 1'b1;
            c_we    = req_we;
            c_err   = req_err;
            c_idx   = req_addr[AW+1:2];
            c_wdata = req_wdata;
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rerr_d  = c_err;
      rdata_d = (!c_we && !c_err) ? mem[c_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is deliberately unreset; rst gating covers the zero-wait commit path.
  always_ff @(posedge clk) begin
    if (commit && c_we && !c_err && !rst) begin
      mem[c_idx] <= c_wdata;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule
